// File: rtl/udp_pkg.sv
// Shared UDP definitions for the udp_tx/udp_rx pair.
// State encodings, header length and checksum constant.
package udp_pkg;

  localparam logic [15:0] UDP_HDR_LEN         = 16'd8;
  localparam logic [15:0] UDP_CHECKSUM_UNUSED = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    RX_HEADER,
    RX_PAYLOAD,
    DISCARD
  } udp_rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HEADER,
    TX_PAYLOAD
  } udp_tx_state_e;

  function automatic logic [15:0] udp_payload_len(
    input logic [15:0] udp_len
  );
    return udp_len - UDP_HDR_LEN;
  endfunction

endpackage

// File: rtl/udp_rx.sv
// UDP receive: parses the 8-byte header, filters on
// LOCAL_PORT_NUM and streams the payload with latency 1.
// Ports:
//   udp_send_clk, rstn       clock, sync active-low reset
//   ip_data_in_valid/_in     byte stream from IP layer
//   app_data_out_valid/_out  payload bytes
//   app_data_length          payload length (UDP len - 8)
//   udp_src_port             source port of the segment
//   app_data_start/_end      first/last payload pulses
//   udp_rx_error             rejected/truncated pulse
module udp_rx #(
  parameter logic [15:0] LOCAL_PORT_NUM = 16'hf000
) (
  input  logic        udp_send_clk,
  input  logic        rstn,
  input  logic        ip_data_in_valid,
  input  logic [7:0]  ip_data_in,
  output logic        app_data_out_valid,
  output logic [7:0]  app_data_out,
  output logic [15:0] app_data_length,
  output logic [15:0] udp_src_port,
  output logic        app_data_start,
  output logic        app_data_end,
  output logic        udp_rx_error
);
  import udp_pkg::*;

  udp_rx_state_e state_q, state_d;

  logic        valid_q, valid_d;
  logic        armed_q, armed_d;
  logic [2:0]  hdr_cnt_q, hdr_cnt_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic        started_q, started_d;
  logic [15:0] app_src_q, app_src_d;
  logic [15:0] app_len_q, app_len_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        start_q, start_d;
  logic        end_q, end_d;
  logic        err_q, err_d;

  logic rise;
  logic hdr_take;

  // armed_q stays low until valid has been seen low once,
  // so a segment already in flight at reset release is skipped.
  assign rise = ip_data_in_valid & ~valid_q & armed_q;

  always_comb begin
    state_d     = state_q;
    valid_d     = ip_data_in_valid;
    armed_d     = armed_q | ~ip_data_in_valid;
    hdr_cnt_d   = hdr_cnt_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    pay_cnt_d   = pay_cnt_q;
    started_d   = started_q;
    app_src_d   = app_src_q;
    app_len_d   = app_len_q;
    out_valid_d = 1'b0;
    out_data_d  = 8'h00;
    start_d     = 1'b0;
    end_d       = 1'b0;
    err_d       = 1'b0;
    hdr_take    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          hdr_take  = 1'b1;
          hdr_cnt_d = 3'd1;
          state_d   = RX_HEADER;
        end
      end

      RX_HEADER: begin
        if (!ip_data_in_valid) begin
          err_d     = 1'b1;
          hdr_cnt_d = 3'd0;
          state_d   = IDLE;
        end else begin
          hdr_take  = 1'b1;
          // 3-bit counter wraps back to 0 after byte 7
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          if (hdr_cnt_q == 3'd7) begin
            state_d = DISCARD;
            if (dst_q == LOCAL_PORT_NUM) begin
              unique case (1'b1)
                (len_q < UDP_HDR_LEN): err_d = 1'b1;
                (len_q == UDP_HDR_LEN): ;
                default: begin
                  app_src_d = src_q;
                  app_len_d = udp_payload_len(len_q);
                  pay_cnt_d = udp_payload_len(len_q);
                  started_d = 1'b0;
                  state_d   = RX_PAYLOAD;
                end
              endcase
            end
          end
        end
      end

      RX_PAYLOAD: begin
        if (ip_data_in_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = ip_data_in;
          start_d     = ~started_q;
          started_d   = 1'b1;
          pay_cnt_d   = pay_cnt_q - 16'd1;
          if (pay_cnt_q == 16'd1) begin
            end_d     = 1'b1;
            started_d = 1'b0;
            state_d   = DISCARD;
          end
        end else begin
          err_d     = 1'b1;
          end_d     = started_q;
          started_d = 1'b0;
          state_d   = IDLE;
        end
      end

      DISCARD: begin
        if (!ip_data_in_valid) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (hdr_take) begin
      unique case (hdr_cnt_q)
        3'd0: src_d[15:8] = ip_data_in;
        3'd1: src_d[7:0]  = ip_data_in;
        3'd2: dst_d[15:8] = ip_data_in;
        3'd3: dst_d[7:0]  = ip_data_in;
        3'd4: len_d[15:8] = ip_data_in;
        3'd5: len_d[7:0]  = ip_data_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge udp_send_clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      armed_q     <= 1'b0;
      hdr_cnt_q   <= 3'd0;
      src_q       <= 16'h0000;
      dst_q       <= 16'h0000;
      len_q       <= 16'h0000;
      pay_cnt_q   <= 16'h0000;
      started_q   <= 1'b0;
      app_src_q   <= 16'h0000;
      app_len_q   <= 16'h0000;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      armed_q     <= armed_d;
      hdr_cnt_q   <= hdr_cnt_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      pay_cnt_q   <= pay_cnt_d;
      started_q   <= started_d;
      app_src_q   <= app_src_d;
      app_len_q   <= app_len_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      start_q     <= start_d;
      end_q       <= end_d;
      err_q       <= err_d;
    end
  end

  assign app_data_out_valid = out_valid_q;
  assign app_data_out       = out_data_q;
  assign app_data_length    = app_len_q;
  assign udp_src_port       = app_src_q;
  assign app_data_start     = start_q;
  assign app_data_end       = end_q;
  assign udp_rx_error       = err_q;

endmodule
